// File: rtl/seq_detector_pkg.sv
// Shared constants for the programmable sequence detector: reset defaults,
// the overlap-mode encoding and the helper that sizes the length field.
package seq_detector_pkg;

  // A length field must be able to hold the value PAT_W itself.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w) + 1;
  endfunction

  localparam logic [31:0] DEF_PATTERN_BITS = 32'h0000_0005;
  localparam int          DEF_LEN_VAL      = 3;
  localparam logic        OVERLAP_ON       = 1'b1;
  localparam logic        DEF_OVERLAP_VAL  = OVERLAP_ON;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increments.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector: loadable pattern/length, overlap
// selection, qualified input and a registered one-cycle match flag.
module seq_detector_prog
  import seq_detector_pkg::*;
#(
  parameter int               PAT_W       = 8,
  parameter int               CNT_W       = 16,
  parameter logic [PAT_W-1:0] DEF_PATTERN = DEF_PATTERN_BITS[PAT_W-1:0],
  parameter int               DEF_LEN     = DEF_LEN_VAL,
  parameter logic             DEF_OVERLAP = DEF_OVERLAP_VAL,
  localparam int              LEN_W       = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_count
);

  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic             overlap;
  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;

  logic             sample;
  logic [PAT_W-1:0] hist_new;
  logic [LEN_W-1:0] fill_new;
  logic [PAT_W-1:0] mask;
  logic             match;
  logic [LEN_W-1:0] len_clamped;

  assign sample      = in_valid && !cfg_load;
  assign len_clamped = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;

  // fill never exceeds len, so it only advances until it reaches it.
  always_comb begin
    hist_new = {hist[PAT_W-2:0], x};
    fill_new = (fill == len) ? fill : fill + 1'b1;
    mask     = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask[i] = (i < 32'(len));
    end
    match = sample && (len != '0) && (fill_new == len) &&
            (((hist_new ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern <= DEF_PATTERN;
      len     <= LEN_W'(DEF_LEN);
      overlap <= DEF_OVERLAP;
      hist    <= '0;
      fill    <= '0;
      y       <= 1'b0;
    end else if (cfg_load) begin
      pattern <= cfg_pattern;
      len     <= len_clamped;
      overlap <= cfg_overlap;
      fill    <= '0;
      y       <= 1'b0;
    end else if (in_valid) begin
      hist <= hist_new;
      // Non-overlapping mode must see a full fresh pattern after each hit.
      fill <= (match && (overlap != OVERLAP_ON)) ? '0 : fill_new;
      y    <= match;
    end else begin
      y <= 1'b0;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_count (
    .clk  (clk),
    .rst  (rst),
    .inc  (match),
    .clr  (cnt_clr),
    .count(match_count)
  );

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
Programmable serial bit-pattern detector and the parametrised successor of the fixed 3-bit Moore detector. It supports a runtime-loadable pattern of 1..PAT_W bits, selectable overlapping or non-overlapping detection, input qualification, and a saturating match counter. It sits on serial bitstreams such as UART/line-decode front ends, where it flags sync words or markers. Output y is Moore-style, registered and glitch-free.

Parameters:
PAT_W, 8, maximum pattern length in bits (2..32)
CNT_W, 16, width of the match counter
DEF_PATTERN, 8'b0000_0101, pattern loaded at reset (right-aligned)
DEF_LEN, 3, pattern length loaded at reset (default gives "101" detection)
DEF_OVERLAP, 1, overlap mode at reset

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (asserted when 0)
x  input  1  serial data bit
in_valid  input  1  x is sampled only when high
cfg_load  input  1  1-cycle strobe; latch cfg_pattern/cfg_len/cfg_overlap
cfg_pattern  input  PAT_W  new pattern, right-aligned
cfg_len  input  $clog2(PAT_W)+1  new pattern length
cfg_overlap  input  1  1 = overlapping, 0 = non-overlapping
cnt_clr  input  1  synchronous clear of match_count
y  output  1  registered match flag
match_count  output  CNT_W  saturating count of matches

Behaviour:
- Reset (rst=0, async): pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP. Clears history, fill=0, y=0, match_count=0.
- Bit order: pattern[len-1] is the first bit received and pattern[0] the last. History shifts left on each valid bit, so hist[0] holds the newest bit.
- fill counter tracks valid bits in the history, saturating at len. Bits present from reset or a load never match.
- A sample cycle is any cycle with in_valid=1 and cfg_load=0. On a sample cycle, the new history/fill is computed. match = (fill_new == len) && (hist_new[len-1:0] == pattern[len-1:0]).
- y <= match on a sample cycle, otherwise y <= 0. Latency: y is high in the clock cycle after the edge that samples the last pattern bit. It stays high for exactly 1 cycle per match.
- Overlap mode: fill is unchanged after a match. Pattern "11" on input 111 gives 2 matches.
- Non-overlap mode: fill <= 0 after a match (history value is don't-care). Pattern "11" on input 111 gives 1 match; 1111 gives 2.
- in_valid=0: history, fill and count hold; y <= 0.
- cfg_load=1: on that edge, latch the new configuration, set fill=0, set y=0. Any x that cycle is ignored, and load wins over in_valid. match_count is not affected.
- cfg_len > PAT_W is clamped to PAT_W. cfg_len=0 disables detection: y stays 0 and the count is frozen until the next load.
- match_count increments on each match and saturates at 2^CNT_W-1.
- cnt_clr: match_count <= 0 and takes priority over a same-cycle match. The increment is lost.
- Reset mid-pattern: partial history is discarded, and detection restarts from fill=0 with the default configuration.

Decomposition:
- Package seq_detector_pkg holds the LEN_W width function, the DEF_* defaults, and the overlap-mode constant.
- One sub-module, sat_counter (CNT_W, inc, clr with priority), for match_count.
- Shift/compare logic and the fill state machine stay in the top level.

Test Plan:
- Defaults, overlap: x=1,0,1,0,1 all valid -> y high in the cycles after bits 3 and 5; match_count=2.
- Load pattern 8'b1101_0011, len 8, overlap=0: stream 11010011 twice -> 2 pulses; re-stream with a 1-cycle in_valid gap mid-pattern -> still matches, and y=0 during the gap.
- Pattern "11" len 2: stream 1111 gives 3 matches with overlap=1 and 2 matches with overlap=0.
- cfg_load asserted mid-pattern with in_valid=1 -> bit ignored, fill=0; a pattern straddling the load is not detected; cfg_len=0 -> no matches over 100 random bits.
- CNT_W=4: 20 matches -> match_count=15 (saturated); cnt_clr in the same cycle as a match -> count 0.
- rst pulsed low asynchronously between clock edges after "10" -> y=0 and count 0 immediately; a following "1" does not match; a full "101" afterwards does.
